conv1d_maxpool: RTL and testbench
=================================

// Module: conv1d_maxpool
// PURPOSE
//  Max-pooling stage directly downstream of the 32-tap multiply-adder/ReLU stage.
//  Consumes its 8-bit ReLU result stream, framed by start/end markers.
//  Emits the maximum of each non-overlapping window of POOL_SIZE samples.
//  Results pass through a small output FIFO with a valid/ready handshake to the next layer.
// PARAMETERS
//  DATA_W      8   sample width; unsigned, since ReLU output is always >= 0
//  POOL_SIZE   4   window length and stride (non-overlapping); legal range 2..16
//  FIFO_DEPTH  4   output FIFO entries; power of 2, >= 2
//  IDX_W       2   $clog2(POOL_SIZE); width of the argmax index
// PORTS
//  clk        in   1        clock, rising edge
//  rst_n      in   1        reset, asynchronous, active-low
//  in_valid   in   1        in_data/in_start/in_end are valid this cycle
//  in_ready   out  1        stage can accept a sample; equals !fifo_full
//  in_data    in   DATA_W   ReLU-activated conv result
//  in_start   in   1        first sample of a frame
//  in_end     in   1        last sample of a frame
//  out_valid  out  1        FIFO head is valid
//  out_ready  in   1        consumer takes the head when out_valid && out_ready
//  out_data   out  DATA_W   pooled maximum
//  out_start  out  1        first pooled value of a frame
//  out_end    out  1        last pooled value of a frame
//  out_idx    out  IDX_W    position of the max within its window (CONV1D_MAXPOOL_ARGMAX_EN only)
//  err_seq    out  1        sticky framing error; cleared only by reset
// BEHAVIOUR
//  Reset values: all outputs 0, FIFO empty, state IDLE, window count 0, running max 0.
//    in_ready goes to 1 after reset.
//  Accept condition: acc = in_valid && in_ready. No state changes without acc.
//  FSM has two states, IDLE and ACC.
//   IDLE:
//    - acc && in_start: load max = in_data, idx = 0, wcnt = 1, first flag = 1, go to ACC.
//    - acc && !in_start: sample is dropped, err_seq <= 1.
//   ACC:
//    - acc && !in_start: if in_data > max (strictly greater), update max and set idx = wcnt.
//      A tie keeps the earlier sample. Then wcnt++.
//    - acc && in_start: the partial window is discarded, err_seq <= 1, and the window
//      restarts with this sample as if arriving in IDLE.
//  Window close: closes when the accepted sample makes wcnt reach POOL_SIZE, or the sample has in_end.
//    - On close, push {max', idx', first flag, in_end} into the FIFO; max'/idx' include the current sample.
//    - Then wcnt = 0 and first flag = 0.
//    - in_end returns to IDLE; otherwise stay in ACC.
//    - A partial last window (frame length not a multiple of POOL_SIZE) is emitted, not dropped.
//    - in_start && in_end on the same sample gives a one-sample frame: a single output with
//      out_start = out_end = 1.
//  Latency: the sample that closes a window is accepted on edge N; out_valid is high after
//    edge N+1 at the earliest, via a registered FIFO write. No combinational path from in_* to out_*.
//  FIFO:
//    - Standard circular buffer: wr/rd pointers of $clog2(FIFO_DEPTH)+1 bits, wrap-around on MSB.
//    - Push and pop in the same cycle are both performed; the count is unchanged.
//    - in_ready = count < FIFO_DEPTH. This is conservative: it is held low when full, even for
//      samples that would not close a window.
//    - out_data/out_start/out_end/out_idx must stay stable while out_valid && !out_ready.
//  Reset mid-frame: the partial window and all FIFO contents are lost. No output until the next in_start.
// CONFIGURATION
//  CONV1D_MAXPOOL_ARGMAX_EN defined:
//    - out_idx carries the argmax position (0..POOL_SIZE-1).
//    - FIFO entry width is DATA_W+2+IDX_W.
//  CONV1D_MAXPOOL_ARGMAX_EN undefined:
//    - No index tracking and no index storage in the FIFO.
//    - out_idx is tied to 0.
//    - All other behaviour is identical.
// TESTING
//  T1: start, then 8 samples 3,9,2,9 | 0,0,7,1 (end on last), out_ready=1
//      -> outputs 9 (start=1, idx=1), then 7 (end=1, idx=2).
//  T2: frame of 6 samples 5,4,3,2 | 8,6 (end on 6th)
//      -> outputs 5 (start), then 8 (end, partial window, idx=0).
//  T3: single sample 0x42 with in_start=in_end=1
//      -> one output 0x42 with out_start=out_end=1; FSM returns to IDLE.
//  T4: out_ready=0, stream a 24-sample frame
//      -> exactly 4 outputs queued, in_ready=0 after the 4th push.
//      -> then out_ready=1: the 4 values drain in order, stable while stalled, in_ready returns to 1.
//  T5: in_valid with no in_start after reset -> dropped, err_seq=1, no output.
//      in_start mid-window after 2 samples -> partial window discarded, new window correct.
//  T6: assert rst_n=0 mid-window with 2 entries queued
//      -> out_valid=0 and FIFO empty immediately; no output until the next in_start.
//  Run T1-T6 with CONV1D_MAXPOOL_ARGMAX_EN both defined and undefined.

Source files
------------

// File: rtl/conv1d_maxpool.sv
// ============================================================================
// Module   : conv1d_maxpool
// Purpose  : Non-overlapping max-pooling of a framed unsigned sample stream,
//            with an output FIFO and valid/ready handshake.
// Options  : define CONV1D_MAXPOOL_ARGMAX_EN to carry the argmax index.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module conv1d_maxpool #(
    parameter int DATA_W     = 8,
    parameter int POOL_SIZE  = 4,
    parameter int FIFO_DEPTH = 4,
    parameter int IDX_W      = $clog2(POOL_SIZE)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_start,
    input  logic              in_end,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_start,
    output logic              out_end,
    output logic [IDX_W-1:0]  out_idx,
    output logic              err_seq
);

    localparam int c_cnt_w = $clog2(POOL_SIZE + 1);
    localparam int c_ptr_w = $clog2(FIFO_DEPTH);
    localparam logic [c_cnt_w-1:0] c_pool  = c_cnt_w'(POOL_SIZE);
    localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);
`ifdef CONV1D_MAXPOOL_ARGMAX_EN
    localparam int c_ent_w = DATA_W + 2 + IDX_W;
`else
    localparam int c_ent_w = DATA_W + 2;
`endif

    typedef enum logic [0:0] {S_IDLE = 1'b0, S_ACC = 1'b1} state_t;

    state_t              r_state;
    logic [DATA_W-1:0]   r_max;
    logic [c_cnt_w-1:0]  r_wcnt;
    logic                r_first;
    logic                r_err;
    logic                r_in_ready;
    logic                r_stg_vld;
    logic [c_ent_w-1:0]  r_stg;
    logic [c_ent_w-1:0]  r_mem [FIFO_DEPTH];
    logic [c_ptr_w:0]    r_wr;
    logic [c_ptr_w:0]    r_rd;
    logic [c_ptr_w:0]    r_occ;

    logic                w_acc;
    logic                w_take;
    logic                w_upd;
    logic [DATA_W-1:0]   w_max;
    logic [c_cnt_w-1:0]  w_cnt;
    logic                w_first;
    logic                w_close;
    logic                w_empty;
    logic                w_pop;
    logic [c_ptr_w:0]    w_occ_next;
    logic [c_ent_w-1:0]  w_entry;
    logic [c_ent_w-1:0]  w_head;

    assign w_acc   = in_valid && r_in_ready;
    assign w_take  = w_acc && (in_start || (r_state == S_ACC));
    // Strictly greater keeps the earlier sample on a tie; an empty window always loads.
    assign w_upd   = in_start || (r_wcnt == '0) || (in_data > r_max);
    assign w_max   = w_upd ? in_data : r_max;
    assign w_cnt   = in_start ? c_cnt_w'(1) : r_wcnt + c_cnt_w'(1);
    assign w_first = in_start || r_first;
    assign w_close = w_take && ((w_cnt == c_pool) || in_end);

    assign w_empty    = (r_wr == r_rd);
    assign w_pop      = !w_empty && out_ready;
    // Occupancy includes the staged entry so the registered write can never overflow.
    assign w_occ_next = r_occ + (c_ptr_w + 1)'(w_close) - (c_ptr_w + 1)'(w_pop);

`ifdef CONV1D_MAXPOOL_ARGMAX_EN
    logic [IDX_W-1:0] r_idx;
    logic [IDX_W-1:0] w_idx;

    assign w_idx   = in_start ? '0 : (w_upd ? IDX_W'(r_wcnt) : r_idx);
    assign w_entry = {w_max, w_idx, w_first, in_end};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_idx <= '0;
        end else if (w_take) begin
            r_idx <= w_close ? '0 : w_idx;
        end
    end

    assign out_idx = out_valid ? w_head[IDX_W+1:2] : '0;
`else
    assign w_entry = {w_max, w_first, in_end};
    assign out_idx = '0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_max   <= '0;
            r_wcnt  <= '0;
            r_first <= 1'b0;
            r_err   <= 1'b0;
        end else if (w_acc) begin
            if ((r_state == S_IDLE) && !in_start) begin
                r_err <= 1'b1;
            end else begin
                if ((r_state == S_ACC) && in_start) begin
                    r_err <= 1'b1;
                end
                if (w_close) begin
                    r_max   <= '0;
                    r_wcnt  <= '0;
                    r_first <= 1'b0;
                    r_state <= in_end ? S_IDLE : S_ACC;
                end else begin
                    r_max   <= w_max;
                    r_wcnt  <= w_cnt;
                    r_first <= w_first;
                    r_state <= S_ACC;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stg_vld  <= 1'b0;
            r_stg      <= '0;
            r_wr       <= '0;
            r_rd       <= '0;
            r_occ      <= '0;
            r_in_ready <= 1'b0;
        end else begin
            r_stg_vld <= w_close;
            if (w_close) begin
                r_stg <= w_entry;
            end
            if (r_stg_vld) begin
                r_wr <= r_wr + 1'b1;
            end
            if (w_pop) begin
                r_rd <= r_rd + 1'b1;
            end
            r_occ      <= w_occ_next;
            r_in_ready <= (w_occ_next < c_depth);
        end
    end

    always_ff @(posedge clk) begin
        if (r_stg_vld) begin
            r_mem[r_wr[c_ptr_w-1:0]] <= r_stg;
        end
    end

    assign w_head    = r_mem[r_rd[c_ptr_w-1:0]];
    assign out_valid = !w_empty;
    assign out_data  = out_valid ? w_head[c_ent_w-1 -: DATA_W] : '0;
    assign out_start = out_valid & w_head[1];
    assign out_end   = out_valid & w_head[0];
    assign in_ready  = r_in_ready;
    assign err_seq   = r_err;

endmodule

`default_nettype wire

// File: tb/tb_conv1d_maxpool.sv
// ============================================================================
// Module   : tb_conv1d_maxpool
// Purpose  : Directed self-checking bench for conv1d_maxpool.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_conv1d_maxpool;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] in_data = '0;
    logic       in_start = 1'b0;
    logic       in_end = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] out_data;
    logic       out_start;
    logic       out_end;
    logic [1:0] out_idx;
    logic       err_seq;

    int total = 0;
    int bad   = 0;
    logic [11:0] q [$];

    always #5 clk = ~clk;

    conv1d_maxpool #(.DATA_W(8), .POOL_SIZE(4), .FIFO_DEPTH(4), .IDX_W(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_start(in_start), .in_end(in_end),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_start(out_start), .out_end(out_end), .out_idx(out_idx),
        .err_seq(err_seq)
    );

    // Records every handshake; inputs change only just after posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready)
            q.push_back({out_data, out_start, out_end, out_idx});
    end

    function automatic logic [11:0] pk(logic [7:0] d, logic s, logic e, logic [1:0] i);
`ifdef CONV1D_MAXPOOL_ARGMAX_EN
        return {d, s, e, i};
`else
        return {d, s, e, 2'b00};
`endif
    endfunction

    function automatic logic [7:0] t4v(int i);
        int w = i / 4;
        int j = i % 4;
        return (j == w % 4) ? 8'(100 + w) : 8'(w);
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send(logic [7:0] d, logic s, logic e);
        int n = 0;
        in_valid = 1'b1; in_data = d; in_start = s; in_end = e;
        @(negedge clk);
        while (!in_ready && n < 200) begin
            n++;
            @(negedge clk);
        end
        if (n >= 200) check("send_timeout", 32'(n), 32'(0));
        @(posedge clk); #1;
        in_valid = 1'b0; in_start = 1'b0; in_end = 1'b0;
    endtask

    task automatic wait_q(int n, string tag);
        int k = 0;
        while (q.size() < n && k < 300) begin
            k++;
            @(negedge clk);
        end
        check(tag, 32'(q.size()), 32'(n));
        @(posedge clk); #1;
    endtask

    task automatic cycles(int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("rst_out_valid", 32'(out_valid), 32'(0));
        check("rst_in_ready", 32'(in_ready), 32'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("rst_ready_up", 32'(in_ready), 32'(1));
        check("rst_err", 32'(err_seq), 32'(0));
    endtask

    initial begin
        // Reset values
        repeat (2) @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'(0));
        check("reset_in_ready", 32'(in_ready), 32'(0));
        check("reset_err", 32'(err_seq), 32'(0));
        check("reset_out_data", 32'(out_data), 32'(0));
        check("reset_out_idx", 32'(out_idx), 32'(0));
        rst_n = 1'b1;
        @(posedge clk); #1;
        check("ready_after_reset", 32'(in_ready), 32'(1));

        // T1: two full windows, with a tie in the first
        out_ready = 1'b1;
        q.delete();
        send(8'd3, 1, 0); send(8'd9, 0, 0); send(8'd2, 0, 0); send(8'd9, 0, 0);
        send(8'd0, 0, 0); send(8'd0, 0, 0); send(8'd7, 0, 0); send(8'd1, 0, 1);
        wait_q(2, "t1_count");
        check("t1_out0", 32'(q[0]), 32'(pk(8'd9, 1, 0, 2'd1)));
        check("t1_out1", 32'(q[1]), 32'(pk(8'd7, 0, 1, 2'd2)));
        check("t1_err", 32'(err_seq), 32'(0));

        // T2: partial last window
        q.delete();
        send(8'd5, 1, 0); send(8'd4, 0, 0); send(8'd3, 0, 0); send(8'd2, 0, 0);
        send(8'd8, 0, 0); send(8'd6, 0, 1);
        wait_q(2, "t2_count");
        check("t2_out0", 32'(q[0]), 32'(pk(8'd5, 1, 0, 2'd0)));
        check("t2_out1", 32'(q[1]), 32'(pk(8'd8, 0, 1, 2'd0)));

        // T3: one-sample frame, with latency check
        out_ready = 1'b0;
        q.delete();
        send(8'h42, 1, 1);
        @(negedge clk);
        check("t3_latency", 32'(out_valid), 32'(0));
        @(negedge clk);
        check("t3_valid", 32'(out_valid), 32'(1));
        check("t3_head", 32'(pk(out_data, out_start, out_end, out_idx)), 32'(pk(8'h42, 1, 1, 2'd0)));
        @(posedge clk); #1;
        out_ready = 1'b1;
        wait_q(1, "t3_count");
        check("t3_drained", 32'(out_valid), 32'(0));
        check("t3_err", 32'(err_seq), 32'(0));

        // T4: backpressure with a 24-sample frame
        out_ready = 1'b0;
        q.delete();
        for (int i = 0; i < 16; i++) send(t4v(i), i == 0, 1'b0);
        check("t4_ready_low", 32'(in_ready), 32'(0));
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("t4_stall_head", 32'(pk(out_data, out_start, out_end, out_idx)),
                  32'(pk(8'd100, 1, 0, 2'd0)));
            check("t4_stall_ready", 32'(in_ready), 32'(0));
        end
        @(posedge clk); #1;
        fork
            begin
                for (int i = 16; i < 24; i++) send(t4v(i), 1'b0, i == 23);
            end
        join_none
        out_ready = 1'b1;
        wait_q(6, "t4_count");
        for (int w = 0; w < 6; w++)
            check($sformatf("t4_out%0d", w), 32'(q[w]),
                  32'(pk(8'(100 + w), w == 0, w == 5, 2'(w % 4))));
        cycles(3);
        check("t4_ready_back", 32'(in_ready), 32'(1));
        check("t4_empty", 32'(out_valid), 32'(0));

        // T5: framing errors
        do_reset();
        q.delete();
        send(8'h55, 0, 0);
        cycles(4);
        check("t5_err_drop", 32'(err_seq), 32'(1));
        check("t5_no_out", 32'(q.size()), 32'(0));
        send(8'd10, 1, 0); send(8'd20, 0, 0);
        send(8'd7, 1, 0); send(8'd3, 0, 0); send(8'd9, 0, 0); send(8'd8, 0, 1);
        wait_q(1, "t5_count");
        check("t5_out0", 32'(q[0]), 32'(pk(8'd9, 1, 1, 2'd2)));
        cycles(4);
        check("t5_single", 32'(q.size()), 32'(1));
        check("t5_err_sticky", 32'(err_seq), 32'(1));

        // T6: reset mid-window with two entries queued
        out_ready = 1'b0;
        q.delete();
        for (int i = 1; i <= 10; i++) send(8'(i), i == 1, 1'b0);
        cycles(2);
        check("t6_queued", 32'(out_valid), 32'(1));
        check("t6_head", 32'(out_data), 32'(4));
        do_reset();
        check("t6_flushed", 32'(out_valid), 32'(0));
        out_ready = 1'b1;
        send(8'd9, 0, 0);
        cycles(6);
        check("t6_no_out", 32'(q.size()), 32'(0));
        send(8'h11, 1, 1);
        wait_q(1, "t6_count");
        check("t6_out0", 32'(q[0]), 32'(pk(8'h11, 1, 1, 2'd0)));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
